// File: rtl/sgemm_udiv_16ns_8ns_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
// Optional macro SGEMM_UDIV_DZ_FAST_EN: divide-by-zero short-circuits straight to DONE and raises dz.
`timescale 1ns/1ps

module sgemm_udiv_16ns_8ns_seq #(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      dz
);

  localparam int N     = DIVIDEND_WIDTH;
  localparam int W     = DIVISOR_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dsr_q, dsr_d;
  logic [W-1:0]     r_q, r_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     quot_q, quot_d;
  logic [W-1:0]     rem_q, rem_d;
`ifdef SGEMM_UDIV_DZ_FAST_EN
  logic             dz_pend_q, dz_pend_d;
  logic             dz_q, dz_d;
`endif

  // The dividend register doubles as the quotient: each step shifts out a
  // dividend bit at the top and shifts the new quotient bit in at the bottom.
  logic [W:0]   r_shift;
  logic [W-1:0] r_sub;
  logic         q_bit;

  always_comb begin
    r_shift = {r_q, dvd_q[N-1]};
    q_bit   = (r_shift >= {1'b0, dsr_q});
    // Only used when r_shift >= divisor, so the true difference fits in W bits.
    r_sub   = r_shift[W-1:0] - dsr_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
`ifdef SGEMM_UDIV_DZ_FAST_EN
    dz_pend_d   = dz_pend_q;
    dz_d        = dz_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          dvd_d   = din0;
          dsr_d   = din1;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef SGEMM_UDIV_DZ_FAST_EN
          dz_pend_d = 1'b0;
          if (din1 == '0) begin
            dvd_d     = '1;
            r_d       = din0[W-1:0];
            dz_pend_d = 1'b1;
            state_d   = S_DONE;
          end
`endif
        end
      end

      S_CALC: begin
        dvd_d = {dvd_q[N-2:0], q_bit};
        r_d   = q_bit ? r_sub : r_shift[W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // First DONE cycle publishes the result; afterwards hold until accepted.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          quot_d      = dvd_q;
          rem_d       = r_q;
`ifdef SGEMM_UDIV_DZ_FAST_EN
          dz_d        = dz_pend_q;
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
`ifdef SGEMM_UDIV_DZ_FAST_EN
      dz_pend_q   <= 1'b0;
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
`ifdef SGEMM_UDIV_DZ_FAST_EN
      dz_pend_q   <= dz_pend_d;
      dz_q        <= dz_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
`ifdef SGEMM_UDIV_DZ_FAST_EN
  assign dz        = dz_q;
`else
  assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_sgemm_udiv_16ns_8ns_seq.sv
// Scoreboard bench for the sequential divider: driver pushes a/b model results, monitor pops on each accepted output.
`timescale 1ns/1ps

module tb_sgemm_udiv_16ns_8ns_seq;

  localparam int N = 16;
  localparam int W = 8;
`ifdef SGEMM_UDIV_DZ_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] din0 = '0;
  logic [W-1:0] din1 = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] quot;
  logic [W-1:0] rem;
  logic         dz;

  typedef struct packed {
    logic [N-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_done = 1'b0;

  sgemm_udiv_16ns_8ns_seq #(
    .ID(1),
    .DIVIDEND_WIDTH(N),
    .DIVISOR_WIDTH(W)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din0(din0),
    .din1(din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot(quot),
    .rem(rem),
    .dz(dz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones and the dividend's low byte.
  function automatic exp_t model(input logic [N-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = {N{1'b1}};
      e.r = a[W-1:0];
    end else begin
      e.q = a / N'(b);
      e.r = W'(a % N'(b));
    end
`ifdef SGEMM_UDIV_DZ_FAST_EN
    e.dz = (b == 0);
`else
    e.dz = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: a result is consumed on the edge after a negedge that sees out_valid && out_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got quot=%0d rem=%0d with no op pending, expected no output", quot, rem);
        end else begin
          e = sb.pop_front();
          chk("quot", 32'(quot), 32'(e.q));
          chk("rem", 32'(rem), 32'(e.r));
          chk("dz", 32'(dz), 32'(e.dz));
        end
      end
    end
  end

  // Returns just after the handshake edge (edge 0 of the operation).
  task automatic send(input logic [N-1:0] a, input logic [W-1:0] b);
    bit accepted;
    accepted = 1'b0;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    for (int k = 0; k < 400; k++) begin
      @(negedge ap_clk);
      if (in_ready) begin
        sb.push_back(model(a, b));
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    din0 = N'($urandom);
    din1 = W'($urandom);
  endtask

  task automatic wait_valid(output int lat, input bit check_busy);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge ap_clk);
      #1;
      if (check_busy) chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(posedge ap_clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("pending_results", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit seen_valid;
    logic [N-1:0] a;
    logic [W-1:0] b;

    // Reset state
    @(negedge ap_clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic op with latency and busy-window checks
    out_ready = 1'b1;
    send(16'd100, 8'd7);
    wait_valid(lat, 1'b1);
    chk("latency_100_7", 32'(lat), 32'd17);
    drain();
    chk("in_ready_after", 32'(in_ready), 32'd1);

    // Boundary operands
    send(16'd65535, 8'd255);
    send(16'd0, 8'd1);
    send(16'd254, 8'd255);
    send(16'd65535, 8'd1);
    drain();

    // Divide by zero
    send(16'h1234, 8'd0);
    wait_valid(lat, 1'b0);
    chk("latency_div0", 32'(lat), 32'(ZERO_LAT));
    drain();

    // Backpressure: result must hold while in_valid pulses are ignored
    out_ready = 1'b0;
    send(16'd50, 8'd3);
    wait_valid(lat, 1'b0);
    chk("latency_bp", 32'(lat), 32'd17);
    for (int c = 0; c < 20; c++) begin
      @(posedge ap_clk);
      #1;
      in_valid = c[0];
      din0 = N'($urandom);
      din1 = W'($urandom);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_quot", 32'(quot), 32'd16);
      chk("bp_rem", 32'(rem), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("pending_bp", 32'(sb.size()), 32'd0);

    // Reset in the middle of CALC
    send(16'd1000, 8'd9);
    repeat (8) @(posedge ap_clk);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quot", 32'(quot), 32'd0);
    chk("midrst_rem", 32'(rem), 32'd0);
    chk("midrst_dz", 32'(dz), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge ap_clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_pulse", 32'(seen_valid), 32'd0);
    send(16'd200, 8'd3);
    wait_valid(lat, 1'b0);
    chk("latency_after_rst", 32'(lat), 32'd17);
    drain();

    // Randomised traffic with input gaps and output stalls
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge ap_clk);
          a = N'($urandom);
          case ($urandom_range(0, 15))
            0:       b = '0;
            1:       b = 8'd1;
            2:       b = 8'd255;
            default: b = W'($urandom);
          endcase
          send(a, b);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge ap_clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
